// File: rtl/stream_pkg.sv
// Shared definitions for the stream <-> AXI address-channel blocks: stream type
// codes, the default Ax word layout and the decoder FSM states.
package stream_pkg;

    localparam logic [2:0] STREAM_AR = 3'd0;
    localparam logic [2:0] STREAM_AW = 3'd1;
    localparam logic [2:0] STREAM_R  = 3'd2;
    localparam logic [2:0] STREAM_W  = 3'd3;
    localparam logic [2:0] STREAM_B  = 3'd4;

    // Default Ax word layout, MSB first: type, id, len, reserved, addr.
    localparam int AX_WORD_WIDTH = 128;
    localparam int AX_TYPE_LSB   = 125;
    localparam int AX_TYPE_WIDTH = 3;
    localparam int AX_ID_LSB     = 93;
    localparam int AX_ID_WIDTH   = 32;
    localparam int AX_LEN_LSB    = 85;
    localparam int AX_LEN_WIDTH  = 8;
    localparam int AX_RSV_LSB    = 64;
    localparam int AX_RSV_WIDTH  = 21;
    localparam int AX_ADDR_LSB   = 0;
    localparam int AX_ADDR_WIDTH = 64;

    typedef enum logic {
        IDLE,
        DROP
    } ax_state_t;

endpackage

// File: rtl/ax_fifo.sv
// Synchronous FIFO holding decoded {id, len, addr} entries; extra pointer bit
// separates full from empty.
module ax_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/stream_to_axi_ax.sv
// Decodes single-beat stream words into AXI AR/AW address requests, queueing
// them in a small FIFO and discarding wrong-type or multi-beat packets.
module stream_to_axi_ax
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH        = AX_WORD_WIDTH,
    parameter int ADDR_WIDTH        = AX_ADDR_WIDTH,
    parameter int ID_WIDTH          = AX_ID_WIDTH,
    parameter int BURST_LEN         = AX_LEN_WIDTH,
    parameter int LOCK_WIDTH        = 2,
    parameter int USER_WIDTH        = 64,
    parameter int STREAM_TYPE_WIDTH = AX_TYPE_WIDTH,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = STREAM_AR,
    parameter int FIFO_DEPTH        = 4,
    parameter logic [2:0]            AX_SIZE   = 3'b100,
    parameter logic [1:0]            AX_BURST  = 2'b01,
    parameter logic [3:0]            AX_CACHE  = 4'b0011,
    parameter logic [2:0]            AX_PROT   = 3'b000,
    parameter logic [LOCK_WIDTH-1:0] AX_LOCK   = '0,
    parameter logic [3:0]            AX_REGION = '0,
    parameter logic [3:0]            AX_QOS    = '0,
    parameter logic [USER_WIDTH-1:0] AX_USER   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] S_tdata,
    input  logic                  S_tvalid,
    output logic                  S_tready,
    input  logic                  S_tlast,
    output logic [ID_WIDTH-1:0]   AXIM_axid,
    output logic [ADDR_WIDTH-1:0] AXIM_axaddr,
    output logic [BURST_LEN-1:0]  AXIM_axlen,
    output logic [2:0]            AXIM_axsize,
    output logic [1:0]            AXIM_axburst,
    output logic [LOCK_WIDTH-1:0] AXIM_axlock,
    output logic [3:0]            AXIM_axcache,
    output logic [2:0]            AXIM_axprot,
    output logic [3:0]            AXIM_axregion,
    output logic [3:0]            AXIM_axqos,
    output logic [USER_WIDTH-1:0] AXIM_axuser,
    output logic                  AXIM_axvalid,
    input  logic                  AXIM_axready,
    output logic                  type_err,
    output logic [15:0]           err_count
);

    localparam int TYPE_LSB    = DATA_WIDTH - STREAM_TYPE_WIDTH;
    localparam int ID_LSB      = TYPE_LSB - ID_WIDTH;
    localparam int LEN_LSB     = ID_LSB - BURST_LEN;
    localparam int ENTRY_WIDTH = ID_WIDTH + BURST_LEN + ADDR_WIDTH;

    logic [STREAM_TYPE_WIDTH-1:0] word_type;
    logic [ENTRY_WIDTH-1:0]       word_entry;
    logic [ENTRY_WIDTH-1:0]       head;
    logic                         unused_reserved;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic                         discard;
    ax_state_t                    state;
    ax_state_t                    next_state;

    assign word_type       = S_tdata[DATA_WIDTH-1:TYPE_LSB];
    assign word_entry      = {S_tdata[TYPE_LSB-1:ID_LSB], S_tdata[ID_LSB-1:LEN_LSB],
                              S_tdata[ADDR_WIDTH-1:0]};
    assign unused_reserved = ^S_tdata[LEN_LSB-1:ADDR_WIDTH];

    assign S_tready     = !fifo_full && !reset;
    assign accept       = S_tvalid && S_tready;
    assign AXIM_axvalid = !fifo_empty && !reset;
    assign pop          = AXIM_axvalid && AXIM_axready;

    ax_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign AXIM_axid     = head[ENTRY_WIDTH-1 -: ID_WIDTH];
    assign AXIM_axlen    = head[ADDR_WIDTH +: BURST_LEN];
    assign AXIM_axaddr   = head[ADDR_WIDTH-1:0];
    assign AXIM_axsize   = AX_SIZE;
    assign AXIM_axburst  = AX_BURST;
    assign AXIM_axlock   = AX_LOCK;
    assign AXIM_axcache  = AX_CACHE;
    assign AXIM_axprot   = AX_PROT;
    assign AXIM_axregion = AX_REGION;
    assign AXIM_axqos    = AX_QOS;
    assign AXIM_axuser   = AX_USER;

    always_comb begin
        next_state = state;
        push       = 1'b0;
        discard    = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!S_tlast) begin
                        discard    = 1'b1;
                        next_state = DROP;
                    end else if (word_type == STREAM_TYPE) begin
                        push = 1'b1;
                    end else begin
                        discard = 1'b1;
                    end
                end
                DROP: begin
                    if (S_tlast) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Only the first beat of a bad packet is counted; DROP swallows the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            type_err  <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= next_state;
            type_err <= discard;
            if (discard && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
